// File: rtl/sr04_meas_scheduler_if.sv
// Bundle between the measurement scheduler, its requesters and the SR04 controller.
// master = scheduler side, slave = requesters plus controller side.
interface sr04_meas_scheduler_if #(
  parameter int N_REQ  = 3,
  parameter int DIST_W = 9
);
  localparam int GNT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  req;
  logic              meas_start;
  logic              meas_done;
  logic [DIST_W-1:0] meas_dist;
  logic [GNT_W-1:0]  gnt_id;
  logic              busy;
  logic [N_REQ-1:0]  rsp_valid;
  logic [DIST_W-1:0] rsp_dist;
  logic              rsp_timeout;

  modport master (
    input  req, meas_done, meas_dist,
    output meas_start, gnt_id, busy, rsp_valid, rsp_dist, rsp_timeout
  );

  modport slave (
    output req, meas_done, meas_dist,
    input  meas_start, gnt_id, busy, rsp_valid, rsp_dist, rsp_timeout
  );
endinterface

// File: rtl/sr04_meas_scheduler.sv
// Round-robin sharing of one SR04 measurement engine among N_REQ requesters, with echo-settle gap.
// Define SR04_SCHED_STATS_EN to add the err_cnt / meas_cnt statistics outputs.
module sr04_meas_scheduler #(
  parameter int N_REQ       = 3,
  parameter int DIST_W      = 9,
  parameter int TIMEOUT_CYC = 3_000_000,
  parameter int GAP_CYC     = 6_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  sr04_meas_scheduler_if.master bus
`ifdef SR04_SCHED_STATS_EN
  ,
  output logic [7:0]            err_cnt,
  output logic [15:0]           meas_cnt
`endif
);
  localparam int GNT_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [GNT_W-1:0] LAST_ID  = GNT_W'(N_REQ - 1);
  localparam logic [GNT_W:0]   NREQ_X   = (GNT_W + 1)'(N_REQ);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [GNT_W-1:0]  rr_ptr_reg;
  logic [GNT_W-1:0]  gnt_id_reg;
  logic              meas_start_reg;
  logic [N_REQ-1:0]  rsp_valid_reg;
  logic [DIST_W-1:0] rsp_dist_reg;
  logic              rsp_timeout_reg;

  logic [GNT_W:0]    req_dist [N_REQ];
  logic              arb_found;
  logic [GNT_W-1:0]  arb_win;
  logic [GNT_W:0]    arb_best;
  logic              wait_expired;

  // Rotational distance of each requester above the rr pointer; the smallest requesting one wins.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dist
    localparam logic [GNT_W:0] IDX = (GNT_W + 1)'(gi);
    assign req_dist[gi] = (IDX >= {1'b0, rr_ptr_reg}) ? (IDX - {1'b0, rr_ptr_reg})
                                                      : (IDX + NREQ_X - {1'b0, rr_ptr_reg});
  end

  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    arb_best  = '1;
    for (int k = 0; k < N_REQ; k++) begin
      if (bus.req[k] && (req_dist[k] < arb_best)) begin
        arb_best  = req_dist[k];
        arb_win   = GNT_W'(k);
        arb_found = 1'b1;
      end
    end
  end

  // A done pulse on the last timer cycle still counts as a real echo.
  assign wait_expired = (state_reg == S_WAIT) && (cnt_reg == TO_LAST) && !bus.meas_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= S_IDLE;
      cnt_reg         <= '0;
      rr_ptr_reg      <= '0;
      gnt_id_reg      <= '0;
      meas_start_reg  <= 1'b0;
      rsp_valid_reg   <= '0;
      rsp_dist_reg    <= '0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      meas_start_reg <= 1'b0;
      rsp_valid_reg  <= '0;
      case (state_reg)
        S_IDLE: begin
          if (arb_found) begin
            gnt_id_reg <= arb_win;
            rr_ptr_reg <= (arb_win == LAST_ID) ? '0 : arb_win + 1'b1;
            state_reg  <= S_START;
          end
        end
        S_START: begin
          meas_start_reg <= 1'b1;
          cnt_reg        <= '0;
          state_reg      <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.meas_done) begin
            rsp_dist_reg    <= bus.meas_dist;
            rsp_timeout_reg <= 1'b0;
            rsp_valid_reg   <= ONE_HOT0 << gnt_id_reg;
            cnt_reg         <= '0;
            state_reg       <= S_GAP;
          end else if (wait_expired) begin
            rsp_dist_reg    <= '1;
            rsp_timeout_reg <= 1'b1;
            rsp_valid_reg   <= ONE_HOT0 << gnt_id_reg;
            cnt_reg         <= '0;
            state_reg       <= S_GAP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_GAP: begin
          // Late echoes arriving here are deliberately dropped.
          if (cnt_reg == GAP_LAST) begin
            state_reg <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.meas_start  = meas_start_reg;
  assign bus.gnt_id      = gnt_id_reg;
  assign bus.busy        = (state_reg != S_IDLE);
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_dist    = rsp_dist_reg;
  assign bus.rsp_timeout = rsp_timeout_reg;

`ifdef SR04_SCHED_STATS_EN
  logic [7:0]  err_cnt_reg;
  logic [15:0] meas_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_reg  <= 8'd0;
      meas_cnt_reg <= 16'd0;
    end else begin
      if (state_reg == S_START) begin
        meas_cnt_reg <= meas_cnt_reg + 16'd1;
      end
      if (wait_expired && (err_cnt_reg != 8'hFF)) begin
        err_cnt_reg <= err_cnt_reg + 8'd1;
      end
    end
  end

  assign err_cnt  = err_cnt_reg;
  assign meas_cnt = meas_cnt_reg;
`endif

endmodule

// File: tb/tb_sr04_meas_scheduler.sv
// Bench for sr04_meas_scheduler: timestamp-based reference model checked every cycle plus directed literals.
// Stats checks are compiled in when SR04_SCHED_STATS_EN is defined.
module tb_sr04_meas_scheduler;
  localparam int N_REQ  = 3;
  localparam int DIST_W = 9;
  localparam int TO     = 100;
  localparam int GAP    = 50;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sr04_meas_scheduler_if #(.N_REQ(N_REQ), .DIST_W(DIST_W)) bus ();

`ifdef SR04_SCHED_STATS_EN
  logic [7:0]  err_cnt;
  logic [15:0] meas_cnt;
`endif

  sr04_meas_scheduler #(
    .N_REQ(N_REQ), .DIST_W(DIST_W), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef SR04_SCHED_STATS_EN
    , .err_cnt(err_cnt),
    .meas_cnt(meas_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N_REQ-1:0] r, input int ptr);
    logic [N_REQ-1:0] sh;
    for (int k = 0; k < N_REQ; k++) begin
      sh = r >> ((ptr + k) % N_REQ);
      if (sh[0]) return (ptr + k) % N_REQ;
    end
    return 0;
  endfunction

  // Reference model: one measurement is a set of timestamps (arbitration, start, response).
  bit               m_active = 0;
  int               m_arb = 0, m_start = 0, m_resp = -1, m_ptr = 0, m_owner = 0;
  logic [8:0]       m_pend_dist = '0, exp_dist = '0;
  bit               m_pend_to = 0, exp_to = 0;
  bit               e_start, e_busy;
  logic [N_REQ-1:0] e_valid;
  int               m_err = 0;
  logic [15:0]      m_meas = '0;

  always @(negedge clk) begin
    if (!rst) begin
      m_active = 0; m_ptr = 0; m_owner = 0; m_resp = -1;
      exp_dist = '0; exp_to = 0; m_err = 0; m_meas = '0;
      chk("rst_meas_start", 32'(bus.meas_start), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_dist", 32'(bus.rsp_dist), 0);
      chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 0);
      chk("rst_gnt_id", 32'(bus.gnt_id), 0);
    end else begin
      e_start = m_active && (cyc == m_start);
      e_busy  = m_active && (cyc > m_arb) && ((m_resp < 0) || (cyc < m_resp + GAP));
      e_valid = '0;
      if (m_active && (cyc == m_resp)) begin
        e_valid  = N_REQ'(1) << m_owner;
        exp_dist = m_pend_dist;
        exp_to   = m_pend_to;
        if (m_pend_to && (m_err < 255)) m_err++;
      end
      if (e_start) m_meas = m_meas + 16'd1;
      chk("model_meas_start", 32'(bus.meas_start), 32'(e_start));
      chk("model_busy", 32'(bus.busy), 32'(e_busy));
      chk("model_rsp_valid", 32'(bus.rsp_valid), 32'(e_valid));
      chk("model_rsp_dist", 32'(bus.rsp_dist), 32'(exp_dist));
      chk("model_rsp_timeout", 32'(bus.rsp_timeout), 32'(exp_to));
      chk("model_gnt_id", 32'(bus.gnt_id), 32'(m_owner));
`ifdef SR04_SCHED_STATS_EN
      chk("model_err_cnt", 32'(err_cnt), 32'(m_err));
      chk("model_meas_cnt", 32'(meas_cnt), 32'(m_meas));
`endif
      // Fold in this cycle's inputs, which the DUT samples on the coming edge.
      if (m_active && (m_resp < 0) && (cyc >= m_start)) begin
        if (bus.meas_done) begin
          m_resp = cyc + 1; m_pend_dist = bus.meas_dist; m_pend_to = 0;
        end else if (cyc == m_start + TO - 1) begin
          m_resp = cyc + 1; m_pend_dist = '1; m_pend_to = 1;
        end
      end
      if ((!m_active || ((m_resp >= 0) && (cyc >= m_resp + GAP))) && (bus.req != '0)) begin
        m_owner  = rr_pick(bus.req, m_ptr);
        m_ptr    = (m_owner + 1) % N_REQ;
        m_arb    = cyc;
        m_start  = cyc + 2;
        m_resp   = -1;
        m_active = 1;
      end
    end
  end

  task automatic wait_start(output int s);
    s = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.meas_start) begin
        s = cyc;
        return;
      end
    end
    chk("meas_start_seen", 0, 1);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) return;
    end
    chk("rsp_valid_seen", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; bus.req = '0; bus.meas_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic pulse_done(input logic [8:0] d);
    bus.meas_done = 1'b1; bus.meas_dist = d;
    @(posedge clk); #1;
    bus.meas_done = 1'b0;
  endtask

  int s, c0, r_prev, pulses;
  int order [4] = '{0, 1, 2, 0};
  logic [2:0] ovec [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    bus.req = '0; bus.meas_done = 1'b0; bus.meas_dist = '0;
    #2;
    chk("init_busy", 32'(bus.busy), 0);
    chk("init_rsp_valid", 32'(bus.rsp_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Single request
    @(posedge clk); #1;
    bus.req = 3'b010; c0 = cyc;
    wait_start(s);
    chk("s1_start_latency", 32'(s - c0), 2);
    chk("s1_gnt_id", 32'(bus.gnt_id), 1);
    repeat (40) @(posedge clk); #1;
    pulse_done(9'd123);
    chk("s1_rsp_valid", 32'(bus.rsp_valid), 32'(3'b010));
    chk("s1_rsp_dist", 32'(bus.rsp_dist), 123);
    chk("s1_rsp_timeout", 32'(bus.rsp_timeout), 0);
    bus.req = '0;
    repeat (49) @(posedge clk); #1;
    chk("s1_busy_last_gap", 32'(bus.busy), 1);
    @(posedge clk); #1;
    chk("s1_busy_low", 32'(bus.busy), 0);

    // Round-robin with all requesters held
    do_reset();
    bus.req = 3'b111;
    r_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_start(s);
      if (k > 0) chk("s2_start_spacing", 32'(s - r_prev), GAP + 2);
      chk("s2_gnt_order", 32'(bus.gnt_id), 32'(order[k]));
      repeat (5 + k) @(posedge clk); #1;
      pulse_done(9'(10 * (k + 1)));
      chk("s2_rsp_valid", 32'(bus.rsp_valid), 32'(ovec[k]));
      chk("s2_rsp_dist", 32'(bus.rsp_dist), 32'(10 * (k + 1)));
      r_prev = cyc;
    end
    bus.req = '0;
    repeat (GAP) @(posedge clk); #1;

    // Timeout, then a late echo during the gap
    bus.req = 3'b001;
    wait_start(s);
    for (int i = 1; i < TO; i++) begin
      @(posedge clk); #1;
      chk("s3_no_early_rsp", 32'(bus.rsp_valid), 0);
    end
    @(posedge clk); #1;
    chk("s3_rsp_valid", 32'(bus.rsp_valid), 32'(3'b001));
    chk("s3_rsp_timeout", 32'(bus.rsp_timeout), 1);
    chk("s3_rsp_dist", 32'(bus.rsp_dist), 32'h1FF);
    bus.req = '0;
    repeat (10) @(posedge clk); #1;
    pulse_done(9'd55);
    pulses = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) pulses++;
    end
    chk("s3_late_echo_pulses", 32'(pulses), 0);
    chk("s3_dist_held", 32'(bus.rsp_dist), 32'h1FF);

    // Done on the last timer cycle, then asynchronous reset mid-WAIT
    bus.req = 3'b001;
    wait_start(s);
    repeat (TO - 1) @(posedge clk); #1;
    pulse_done(9'd77);
    chk("s4_rsp_valid", 32'(bus.rsp_valid), 32'(3'b001));
    chk("s4_rsp_timeout", 32'(bus.rsp_timeout), 0);
    chk("s4_rsp_dist", 32'(bus.rsp_dist), 77);
    wait_start(s);
    repeat (20) @(posedge clk); #2;
    chk("s4_busy_before_rst", 32'(bus.busy), 1);
    rst = 1'b0;
    #1;
    chk("s4_async_busy", 32'(bus.busy), 0);
    chk("s4_async_gnt_id", 32'(bus.gnt_id), 0);
    chk("s4_async_rsp_dist", 32'(bus.rsp_dist), 0);
    chk("s4_async_rsp_timeout", 32'(bus.rsp_timeout), 0);
    chk("s4_async_meas_start", 32'(bus.meas_start), 0);
    bus.req = 3'b100;
    @(posedge clk); #1;
    rst = 1'b1; c0 = cyc;
    wait_start(s);
    chk("s4_post_rst_latency", 32'(s - c0), 2);
    chk("s4_post_rst_gnt", 32'(bus.gnt_id), 2);
    @(posedge clk); #1;
    pulse_done(9'd5);
    chk("s4_post_rst_rsp", 32'(bus.rsp_valid), 32'(3'b100));
    bus.req = 3'b011;
    wait_start(s);
    chk("s4_wrap_gnt", 32'(bus.gnt_id), 0);
    @(posedge clk); #1;
    pulse_done(9'd6);
    bus.req = '0;
    repeat (GAP + 2) @(posedge clk); #1;

`ifdef SR04_SCHED_STATS_EN
    // Statistics: three timeouts and one echo, then saturation
    do_reset();
    bus.req = 3'b001;
    for (int k = 0; k < 3; k++) begin
      wait_start(s);
      wait_rsp();
    end
    wait_start(s);
    repeat (3) @(posedge clk); #1;
    pulse_done(9'd200);
    chk("s5_err_cnt", 32'(err_cnt), 3);
    chk("s5_meas_cnt", 32'(meas_cnt), 4);
    for (int k = 0; k < 260; k++) begin
      wait_start(s);
      wait_rsp();
    end
    @(posedge clk); #1;
    chk("s5_err_cnt_sat", 32'(err_cnt), 255);
    chk("s5_meas_cnt_total", 32'(meas_cnt), 264);
    bus.req = '0;
`endif

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end
endmodule

// File: doc/sr04_meas_scheduler.md
Name: sr04_meas_scheduler

Overview:
- Shares one SR04_Controller measurement engine among N_REQ requesters, e.g. button-driven display, auto-scan FSM and UART query.
- Round-robin arbitration; issues one start pulse per granted request.
- Waits for done or timeout, returns the distance to the winning requester.
- Enforces a minimum echo-settle gap between successive triggers so residual echoes never corrupt the next measurement.

Parameters:
N_REQ, 3, number of requesters (2..8)
DIST_W, 9, distance width in cm, as produced by the controller
TIMEOUT_CYC, 3_000_000, clocks to wait for meas_done after meas_start (30 ms @100 MHz)
GAP_CYC, 6_000_000, idle clocks after each measurement before the next start (60 ms @100 MHz)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-low reset
req  in  N_REQ  level request per requester; held until own rsp_valid bit
meas_start  out  1  one-cycle start pulse to the SR04 controller
meas_done  in  1  one-cycle pulse from the controller, distance valid
meas_dist  in  DIST_W  distance from the controller, sampled when meas_done=1
gnt_id  out  $clog2(N_REQ)  index of the requester currently owning the engine
busy  out  1  high in every state except IDLE
rsp_valid  out  N_REQ  one-hot, one-cycle response strobe to the granted requester
rsp_dist  out  DIST_W  distance for the current response; held until the next response
rsp_timeout  out  1  qualifies rsp_valid; 1 = no echo within TIMEOUT_CYC

Behaviour:
- Reset (rst=0, asynchronous) forces all of the following regardless of state or counters:
  - state=IDLE; meas_start, busy, rsp_valid, rsp_timeout = 0
  - rsp_dist=0, gnt_id=0
  - rr pointer = 0, so requester 0 has highest priority first
- States: IDLE, START, WAIT, GAP.
- IDLE:
  - If req != 0, pick the first set bit scanning from the rr pointer upward, wrapping modulo N_REQ.
  - Register gnt_id = winner; rr pointer = winner+1, wrapping to 0; go to START.
  - Arbitration takes 1 cycle. Requests sampled in IDLE only.
- START: meas_start=1 for exactly this one cycle; wait timer cleared to 0; next state WAIT.
- WAIT: timer increments every cycle.
  - meas_done=1: rsp_dist <= meas_dist, rsp_timeout <= 0, rsp_valid[gnt_id] <= 1 on the next cycle; go to GAP.
  - Timer reaches TIMEOUT_CYC-1 with no done: rsp_dist <= all ones, rsp_timeout <= 1, rsp_valid[gnt_id] pulse; go to GAP.
  - meas_done and timeout in the same cycle: done wins.
- GAP: counter runs GAP_CYC cycles, then returns to IDLE. meas_done arriving during GAP (late echo) is ignored.
- Latencies:
  - req rising in IDLE -> meas_start at cycle +2.
  - meas_done -> rsp_valid at +1.
  - rsp_valid -> earliest next meas_start at GAP_CYC+2.
- Requester dropping req after grant: measurement still completes; the rsp_valid pulse is still issued and may be ignored.
- Requester still holding req after its response: it re-enters arbitration after GAP, behind any other pending requesters.
- gnt_id is stable from START through GAP.
- Counters sized $clog2(max(TIMEOUT_CYC,GAP_CYC)+1); no wrap-around.
- Only one requester bit of rsp_valid is ever high; never high with rsp_timeout undefined.

Optional Feature:
- Macro SR04_SCHED_STATS_EN.
- Defined:
  - Adds output err_cnt[7:0]: saturating count of timeout responses since reset; holds at 255; reset to 0.
  - Adds output meas_cnt[15:0]: wrapping count of meas_start pulses.
- Undefined: neither port exists; no counters are synthesized; all other behaviour is identical.

Test Plan:
Bench parameters for all scenarios: N_REQ=3, TIMEOUT_CYC=100, GAP_CYC=50. Scenarios 1-4 have SR04_SCHED_STATS_EN undefined; scenario 5 defines it.
1. Single request:
   - Stimulus: req=3'b010 held; meas_done with meas_dist=123 forty cycles after meas_start.
   - Response: meas_start 2 cycles after req; gnt_id=1; rsp_valid=3'b010 one cycle after done; rsp_dist=123, rsp_timeout=0; busy low 50 cycles later.
2. Round-robin:
   - Stimulus: req=3'b111 held; every measurement answered with dist 10, 20, 30, 40.
   - Response: grant order 0,1,2,0; each meas_start separated by ≥ GAP_CYC+2 cycles after the prior rsp_valid.
3. Timeout:
   - Stimulus: req=3'b001; meas_done never asserted.
   - Response: rsp_valid=3'b001 exactly 100 cycles after meas_start, with rsp_timeout=1 and rsp_dist=9'h1FF.
   - Follow-up: meas_done injected during GAP produces no response.
4. Boundary and reset:
   - Stimulus: meas_done on the same cycle the timer reaches 99.
   - Response: rsp_timeout=0 and the distance is returned.
   - Then: assert rst=0 mid-WAIT; all outputs are 0 immediately, without waiting for a clock edge; after release, req=3'b100 is granted with gnt_id=2 and the rr pointer starts from 0.
5. Stats (SR04_SCHED_STATS_EN defined):
   - Stimulus: 3 timeouts then 1 valid measurement.
   - Response: err_cnt=3, meas_cnt=4.
   - Then: force 260 timeouts; err_cnt saturates at 255.
